braille_cell_serializer: RTL and testbench
==========================================

BRAILLE_CELL_SERIALIZER -- requirements
Module: braille_cell_serializer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of entries in the cell FIFO (power of two, 2..16).
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port R  input  1  asynchronous active-low reset (R=0 resets immediately, independent of CLK).
REQ-004 The block SHALL have port CELL  input  6  braille cell; CELL[0]=dot1 ... CELL[5]=dot6.
REQ-005 The block SHALL have port CELL_VALID  input  1  CELL is valid this cycle.
REQ-006 The block SHALL have port CELL_READY  output  1  block can accept a cell this cycle.
REQ-007 The block SHALL have port SO  output  1  serial dot stream feeding the downstream decoder's serial input.
REQ-008 The block SHALL have port FRAME  output  1  high while SO carries dot1 of a cell.
REQ-009 The block SHALL have port BUSY  output  1  high while SO carries any dot of a cell.
REQ-010 The block SHALL have port LEVEL  output  5  current FIFO occupancy, 0..DEPTH.

Function
REQ-011 A push SHALL occur on a rising edge where CELL_VALID=1 and CELL_READY=1; CELL is written at the FIFO tail.
REQ-012 CELL_READY SHALL equal (LEVEL != DEPTH), from registered state only; it SHALL NOT depend on CELL_VALID or on a same-cycle pop.
REQ-013 The serializer SHALL have states IDLE and SHIFT, plus a 3-bit dot counter DC (0..5).
REQ-014 In IDLE with LEVEL>0 at a rising edge: pop head into the shift register, go to SHIFT, DC=0, SO=dot1, FRAME=1, BUSY=1.
REQ-015 In IDLE with LEVEL=0: remain IDLE, SO=0, FRAME=0, BUSY=0.
REQ-016 In SHIFT with DC<5 at a rising edge: DC increments, SO = next dot (dot1,dot2,...,dot6 order), FRAME=0, BUSY=1.
REQ-017 In SHIFT with DC=5 and LEVEL>0: pop next cell, DC=0, SO=its dot1, FRAME=1; no idle gap between back-to-back cells (exactly 6 clocks per cell).
REQ-018 In SHIFT with DC=5 and LEVEL=0: go to IDLE, SO=0, FRAME=0, BUSY=0.
REQ-019 Latency: a cell pushed at edge k into an empty FIFO with the serializer IDLE SHALL have dot1 on SO after edge k+1; a cell SHALL NOT be pushed and popped on the same edge.
REQ-020 Simultaneous push and pop on one edge SHALL leave LEVEL unchanged; head/tail pointers wrap modulo DEPTH.
REQ-021 A push attempt while full (CELL_VALID=1, CELL_READY=0) SHALL be ignored with no state change.
REQ-022 SO, FRAME, BUSY SHALL be registered outputs with no combinational path from any input.

Reset
REQ-023 On R=0: state=IDLE, DC=0, FIFO pointers=0, LEVEL=0, SO=0, FRAME=0, BUSY=0, CELL_READY=1, all asynchronously.
REQ-024 Reset asserted mid-cell SHALL abandon the cell in flight and all queued cells; after R returns high, the first push follows REQ-019 timing.
REQ-025 FIFO storage contents need not be reset.

Verification
REQ-026 Single cell: after reset, push CELL=6'b001001 (dots 1,4) once -> SO over next 6 clocks = 1,0,0,1,0,0; FRAME high on first clock only; BUSY high 6 clocks then low; SO=0 thereafter.
REQ-027 Back-to-back: push 6'b001001 then 6'b011101 on consecutive edges -> SO = 1,0,0,1,0,0,1,0,1,1,1,0 with no gap; FRAME high on clocks 1 and 7.
REQ-028 Full: hold CELL_VALID=1 for DEPTH+3 edges with serializer stalled only by rate -> LEVEL reaches DEPTH, CELL_READY=0, excess pushes dropped; every accepted cell emerges in push order.
REQ-029 Simultaneous push/pop: with LEVEL=2, push on the DC=5 edge -> LEVEL stays 2, stream continuous.
REQ-030 Reset mid-operation: pull R low during DC=3 of a cell with LEVEL=3 -> SO, FRAME, BUSY, LEVEL go to 0 immediately; CELL_READY=1; no abandoned cell ever appears on SO.
REQ-031 Idle gap: push one cell, wait 10 clocks, push another -> SO=0 and BUSY=0 during the gap; second cell's dot1 appears one edge after its push.

Source files
------------

// File: rtl/braille_cell_serializer.sv
// ---------------------------------------------------------------------------
// braille_cell_serializer
//
// Purpose:
//   Accepts 6-dot braille cells through a valid/ready handshake into a small
//   FIFO. Each cell is sent out as a serial dot stream, dot1 first and dot6
//   last, one dot per clock. Cells that are already queued follow each other
//   with no idle clock between them, so every cell takes exactly 6 clocks.
//
// Ports:
//   CLK         in   system clock; all state changes on its rising edge
//   R           in   asynchronous active-low reset
//   CELL[5:0]   in   braille cell, CELL[0] = dot1 ... CELL[5] = dot6
//   CELL_VALID  in   CELL is valid this cycle
//   CELL_READY  out  a cell can be accepted this cycle (FIFO not full)
//   SO          out  serial dot stream (registered)
//   FRAME       out  high while SO carries dot1 of a cell (registered)
//   BUSY        out  high while SO carries any dot of a cell (registered)
//   LEVEL[4:0]  out  FIFO occupancy, 0..DEPTH
//
// Parameters:
//   DEPTH       number of FIFO entries; power of two, 2..16
// ---------------------------------------------------------------------------
module braille_cell_serializer #(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       R,
    input  logic [5:0] CELL,
    input  logic       CELL_VALID,
    output logic       CELL_READY,
    output logic       SO,
    output logic       FRAME,
    output logic       BUSY,
    output logic [4:0] LEVEL
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);
    localparam logic [2:0] LAST_DC = 3'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // FIFO storage. It is not reset because the pointers and the level
    // decide which entries hold real cells.
    logic [5:0]       mem [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [4:0]       level_reg;

    // Serializer state
    state_t     state_reg;
    logic [2:0] dc_reg;
    logic [5:0] shift_reg;
    logic       so_reg;
    logic       frame_reg;
    logic       busy_reg;

    logic       push;
    logic       pop;
    logic [5:0] head_cell;

    // Ready depends only on registered occupancy. A pop in the same cycle
    // does not make room early, which keeps the handshake free of
    // combinational loops.
    assign CELL_READY = (level_reg != DEPTH_L);

    assign push = CELL_VALID && CELL_READY;

    // A pop uses the occupancy from before this edge. A cell pushed on an
    // edge is therefore never popped on that same edge. A pop happens when
    // the serializer is idle, or when it is on the last dot of a cell, so
    // that the next cell follows with no gap.
    assign pop = (level_reg != 5'd0) &&
                 ((state_reg == IDLE) || (dc_reg == LAST_DC));

    assign head_cell = mem[head_reg];

    // Storage write port
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[tail_reg] <= CELL;
        end
    end

    // Pointers, occupancy and the serializer FSM
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            level_reg <= 5'd0;
            state_reg <= IDLE;
            dc_reg    <= 3'd0;
            shift_reg <= 6'd0;
            so_reg    <= 1'b0;
            frame_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end

            // A push and a pop on the same edge leave the level unchanged
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 5'd1;
                2'b01:   level_reg <= level_reg - 5'd1;
                default: level_reg <= level_reg;
            endcase

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        state_reg <= SHIFT;
                        dc_reg    <= 3'd0;
                        shift_reg <= head_cell;
                        so_reg    <= head_cell[0];
                        frame_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end else begin
                        so_reg    <= 1'b0;
                        frame_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (dc_reg != LAST_DC) begin
                        // SO always shows bit 0 of shift_reg, so shifting
                        // right brings the next dot into place.
                        dc_reg    <= dc_reg + 3'd1;
                        shift_reg <= {1'b0, shift_reg[5:1]};
                        so_reg    <= shift_reg[1];
                        frame_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end else if (pop) begin
                        // Load the next cell straight after dot6
                        dc_reg    <= 3'd0;
                        shift_reg <= head_cell;
                        so_reg    <= head_cell[0];
                        frame_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        dc_reg    <= 3'd0;
                        so_reg    <= 1'b0;
                        frame_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    dc_reg    <= 3'd0;
                    so_reg    <= 1'b0;
                    frame_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign SO    = so_reg;
    assign FRAME = frame_reg;
    assign BUSY  = busy_reg;
    assign LEVEL = level_reg;

endmodule

// File: tb/tb_braille_cell_serializer.sv
// ---------------------------------------------------------------------------
// tb_braille_cell_serializer
//
// Self-checking bench for braille_cell_serializer. The reference model is a
// queue of pending cells plus the cell currently on the wire and the index of
// the dot it is sending. A separate scoreboard rebuilds each cell from the
// DUT's serial stream and compares it with the cells accepted, in order.
// ---------------------------------------------------------------------------
module tb_braille_cell_serializer;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       R = 1'b0;
    logic [5:0] CELL = 6'd0;
    logic       CELL_VALID = 1'b0;
    logic       CELL_READY;
    logic       SO;
    logic       FRAME;
    logic       BUSY;
    logic [4:0] LEVEL;

    braille_cell_serializer #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .R          (R),
        .CELL       (CELL),
        .CELL_VALID (CELL_VALID),
        .CELL_READY (CELL_READY),
        .SO         (SO),
        .FRAME      (FRAME),
        .BUSY       (BUSY),
        .LEVEL      (LEVEL)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [5:0] q[$];      // cells waiting in the FIFO
    logic [5:0] cur;       // cell currently on the wire
    int         pos = -1;  // dot index being sent, -1 when idle
    logic [5:0] acc[$];    // accepted cells not yet seen on SO

    // Stream reassembly state
    logic [5:0] asm_cell;
    int         nbits = -1;

    int so_log[$];
    int frame_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge of the model, using the pre-edge occupancy
    task automatic model_edge(input logic v, input logic [5:0] c);
        int  sz;
        bit  do_pop;
        bit  do_push;
        sz      = q.size();
        do_pop  = ((pos < 0) || (pos == 5)) && (sz > 0);
        do_push = v && (sz < DEPTH);
        if (pos >= 0 && pos < 5) begin
            pos++;
        end else if (do_pop) begin
            cur = q.pop_front();
            pos = 0;
        end else begin
            pos = -1;
        end
        if (do_push) begin
            q.push_back(c);
            acc.push_back(c);
        end
    endtask

    task automatic check_outputs();
        logic       exp_so;
        logic [5:0] exp_cell;
        exp_so = (pos >= 0) ? cur[pos] : 1'b0;
        check("SO",         SO,         exp_so);
        check("FRAME",      FRAME,      pos == 0);
        check("BUSY",       BUSY,       pos >= 0);
        check("LEVEL",      LEVEL,      q.size());
        check("CELL_READY", CELL_READY, q.size() < DEPTH);
        so_log.push_back(int'(SO));
        frame_log.push_back(int'(FRAME));

        // Rebuild cells from the DUT stream and compare them in order
        if (FRAME) begin
            asm_cell = 6'd0;
            nbits    = 0;
        end
        if (BUSY && nbits >= 0 && nbits < 6) begin
            asm_cell[nbits] = SO;
            nbits++;
            if (nbits == 6) begin
                if (acc.size() == 0) begin
                    check("order_extra_cell", 1, 0);
                end else begin
                    exp_cell = acc.pop_front();
                    check("order", asm_cell, exp_cell);
                    $display("cell %02h serialized (expected %02h)", asm_cell, exp_cell);
                end
                nbits = -1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [5:0] c);
        CELL_VALID = v;
        CELL       = c;
        @(posedge CLK);
        model_edge(v, c);
        #1;
        check_outputs();
    endtask

    // Reset applied between edges; outputs are checked before the next edge
    task automatic do_reset();
        #2;
        R          = 1'b0;
        CELL_VALID = 1'b0;
        #1;
        q.delete();
        acc.delete();
        pos   = -1;
        nbits = -1;
        check("rst_SO",    SO,         1'b0);
        check("rst_FRAME", FRAME,      1'b0);
        check("rst_BUSY",  BUSY,       1'b0);
        check("rst_LEVEL", LEVEL,      5'd0);
        check("rst_READY", CELL_READY, 1'b1);
        @(negedge CLK);
        R = 1'b1;
    endtask

    int exp_single[7]  = '{1, 0, 0, 1, 0, 0, 0};
    int exp_b2b[12]    = '{1, 0, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0};
    int lvl_max;
    int p;

    initial begin
        // Reset state at power-up
        #3;
        check("init_SO",    SO,         1'b0);
        check("init_FRAME", FRAME,      1'b0);
        check("init_BUSY",  BUSY,       1'b0);
        check("init_LEVEL", LEVEL,      5'd0);
        check("init_READY", CELL_READY, 1'b1);
        @(negedge CLK);
        R = 1'b1;

        // Single cell: dots 1 and 4
        step(1'b1, 6'b001001);
        check("single_latency_so", SO, 1'b0);
        so_log.delete();
        frame_log.delete();
        repeat (7) step(1'b0, 6'd0);
        for (int i = 0; i < 7; i++) begin
            check("single_so", so_log[i], exp_single[i]);
            check("single_frame", frame_log[i], (i == 0) ? 1 : 0);
        end

        // Back-to-back cells with no gap
        step(1'b1, 6'b001001);
        so_log.delete();
        frame_log.delete();
        step(1'b1, 6'b011101);
        repeat (11) step(1'b0, 6'd0);
        for (int i = 0; i < 12; i++) begin
            check("b2b_so", so_log[i], exp_b2b[i]);
            check("b2b_frame", frame_log[i], (i == 0 || i == 6) ? 1 : 0);
        end
        repeat (4) step(1'b0, 6'd0);

        // Fill the FIFO by holding valid while the serializer runs
        lvl_max = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            step(1'b1, 6'($urandom));
            if (int'(LEVEL) > lvl_max) lvl_max = int'(LEVEL);
        end
        check("full_level_max", lvl_max, DEPTH);
        check("full_ready_low", CELL_READY, 1'b0);
        repeat (DEPTH * 6 + 8) step(1'b0, 6'd0);

        // Reset in the middle of a cell with three cells queued
        step(1'b1, 6'h2a);
        step(1'b1, 6'h15);
        step(1'b1, 6'h3f);
        step(1'b1, 6'h07);
        step(1'b0, 6'd0);
        check("midrst_level_before", LEVEL, 5'd3);
        do_reset();
        repeat (3) step(1'b0, 6'd0);
        step(1'b1, 6'h21);
        check("midrst_push_so", SO, 1'b0);
        step(1'b0, 6'd0);
        check("midrst_first_dot", SO, 1'b1);
        repeat (8) step(1'b0, 6'd0);

        // Idle gap between two cells
        step(1'b1, 6'h12);
        repeat (10) step(1'b0, 6'd0);
        check("gap_busy", BUSY, 1'b0);
        step(1'b1, 6'h33);
        step(1'b0, 6'd0);
        check("gap_frame", FRAME, 1'b1);
        repeat (8) step(1'b0, 6'd0);

        // Random traffic at several densities with occasional resets
        for (int i = 0; i < 800; i++) begin
            case ((i / 100) % 4)
                0:       p = 10;
                1:       p = 30;
                2:       p = 60;
                default: p = 95;
            endcase
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < p, 6'($urandom));
            end
        end

        // Drain and confirm every accepted cell came out
        repeat (DEPTH * 6 + 8) step(1'b0, 6'd0);
        check("drain_all_cells_out", acc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
